// File: rtl/packer_pkg.sv
// packer_pkg: shared constants and state encoding for the packer arbiter.
package packer_pkg;
  localparam int pix_width_c = 2;
  localparam int num_req_c = 4;
  typedef enum logic {IDLE, BURST} state_e;
endpackage

// File: rtl/counter_roll.sv
// counter_roll: up counter that wraps to zero after max_val_p, with synchronous clear.
module counter_roll #(
  parameter int max_val_p = 3,
  parameter int width_p = $clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);
  logic [width_p-1:0] count_q, count_d;
  always_comb
    count_d = clear_i ? '0 : !up_i ? count_q : (count_q == width_p'(max_val_p)) ? '0 : count_q + 1'b1;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) count_q <= '0;
    else count_q <= count_d;
  assign count_o = count_q;
endmodule

// File: rtl/rr_pick.sv
// rr_pick: round-robin selector, first request strictly above the pointer, wrapping.
module rr_pick #(
  parameter int n_p = 4,
  parameter int id_w_p = $clog2(n_p)
) (
  input  logic [n_p-1:0]    req_i,
  input  logic [id_w_p-1:0] ptr_i,
  output logic [n_p-1:0]    pick_o,
  output logic [id_w_p-1:0] id_o
);
  localparam logic [2*n_p-1:0] one_lp = 1;
  logic [2*n_p-1:0] masked, low;
  always_comb begin
    // Upper copy guarantees a hit at or below ptr+n whenever any request is set.
    masked = {req_i, req_i} & ~((one_lp << ptr_i << 1) - one_lp);
    low = masked & (~masked + one_lp);
    pick_o = low[n_p-1:0] | low[2*n_p-1:n_p];
    id_o = '0;
    for (int i = 0; i < n_p; i++) if (pick_o[i]) id_o = id_w_p'(i);
  end
endmodule

// File: rtl/packer_arbiter.sv
// packer_arbiter: round-robin burst arbiter feeding a single pixel packer input.
module packer_arbiter import packer_pkg::*; #(
  parameter int num_req_p = num_req_c,
  parameter int width_p = pix_width_c,
  parameter int beats_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [num_req_p*width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]         req_valid_i,
  output logic [num_req_p-1:0]         req_ready_o,
  output logic [width_p-1:0]           data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [num_req_p-1:0]         grant_o,
  output logic [$clog2(num_req_p)-1:0] grant_id_o,
  output logic                         busy_o
);
  localparam int id_w_lp = $clog2(num_req_p);
  localparam int cnt_w_lp = $clog2(beats_p);
  state_e state_q, state_d;
  logic [num_req_p-1:0] grant_q, grant_d, pick;
  logic [id_w_lp-1:0] id_q, id_d, ptr_q, ptr_d, pick_id;
  logic [cnt_w_lp-1:0] cnt;
  logic fire, last;
  rr_pick #(.n_p(num_req_p)) u_pick (
    .req_i(req_valid_i), .ptr_i(ptr_q), .pick_o(pick), .id_o(pick_id)
  );
  counter_roll #(.max_val_p(beats_p - 1)) u_beats (
    .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(!busy_o), .up_i(fire), .count_o(cnt)
  );
  assign busy_o = state_q == BURST;
  assign grant_o = grant_q;
  assign grant_id_o = id_q;
  // Data and handshake pass straight through; no pipeline stage on the beat path.
  assign data_o = busy_o ? req_data_i[id_q*width_p +: width_p] : '0;
  assign valid_o = busy_o & req_valid_i[id_q];
  assign req_ready_o = grant_q & {num_req_p{ready_i}};
  assign fire = valid_o & ready_i;
  assign last = fire && cnt == cnt_w_lp'(beats_p - 1);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d = id_q;
    ptr_d = ptr_q;
    if (state_q == IDLE && |req_valid_i) begin
      state_d = BURST;
      grant_d = pick;
      id_d = pick_id;
    end else if (state_q == BURST && last) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d = id_q;
    end
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q <= '0;
      ptr_q <= id_w_lp'(num_req_p - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
    end
endmodule

// File: tb/tb_packer_arbiter.sv
// tb_packer_arbiter: directed checks of grant order, burst length and handshake pass-through.
module tb_packer_arbiter;
  logic clk = 0, rst_n = 0;
  logic [7:0] req_data = '0;
  logic [3:0] req_valid = '0, req_ready, grant;
  logic [1:0] data, gid;
  logic valid, ready = 0, busy;
  logic [3:0] r2_data = '0;
  logic [1:0] r2_valid = '0, r2_rdy, grant2;
  logic [1:0] data2;
  logic gid2, valid2, busy2, r2_ready = 0;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  packer_arbiter dut (
    .clk_i(clk), .reset_ni(rst_n), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .data_o(data), .valid_o(valid), .ready_i(ready),
    .grant_o(grant), .grant_id_o(gid), .busy_o(busy)
  );
  packer_arbiter #(.num_req_p(2), .beats_p(8)) dut2 (
    .clk_i(clk), .reset_ni(rst_n), .req_data_i(r2_data), .req_valid_i(r2_valid),
    .req_ready_o(r2_rdy), .data_o(data2), .valid_o(valid2), .ready_i(r2_ready),
    .grant_o(grant2), .grant_id_o(gid2), .busy_o(busy2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic burst(input string tag, input int g);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk({tag, "_grant"}, grant, 1 << g);
      chk({tag, "_gid"}, gid, g);
      chk({tag, "_fire"}, int'(valid & ready), 1);
      chk({tag, "_rdy"}, req_ready, 1 << g);
    end
    @(negedge clk); #1;
    chk({tag, "_bubble_busy"}, busy, 0);
    chk({tag, "_bubble_grant"}, grant, 0);
    chk({tag, "_bubble_gid"}, gid, g);
  endtask

  initial begin
    int stream[4] = '{1, 2, 3, 0};
    int ready_pat[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    logic [7:0] pbyte;
    // Test 1: single requester, data stream packs into 8'h39
    req_valid = 4'b0010;
    ready = 1;
    req_data[3:2] = 2'd1;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_gid", gid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", data, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("t1_arb_latency", busy, 0);
    pbyte = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_data[3:2] = 2'(stream[k]);
      #1;
      chk("t1_grant", grant, 4'b0010);
      chk("t1_fire", int'(valid & ready), 1);
      chk("t1_data", data, stream[k]);
      pbyte = pbyte | (8'(data) << (2 * k));
    end
    chk("t1_byte", pbyte, 8'h39);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_gid", gid, 1);
    // Test 2: all valid, grants rotate 0..3 three times
    req_valid = 4'b1111;
    do_reset();
    #1;
    chk("t2_arb_latency", busy, 0);
    for (int b = 0; b < 12; b++) burst($sformatf("t2_b%0d", b), b % 4);
    // Test 3: granted requester stalls; other requester must not pre-empt
    req_valid = 4'b0100;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 4'b0101;
      #1;
      chk("t3_grant", grant, 4'b0100);
      chk("t3_fire", int'(valid & ready), 1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      chk("t3_hold_grant", grant, 4'b0100);
      chk("t3_hold_valid", valid, 0);
      chk("t3_hold_rdy", req_ready, 4'b0100);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 4'b0101;
      #1;
      chk("t3_resume_fire", int'(valid & ready), 1);
      chk("t3_resume_grant", grant, 4'b0100);
    end
    @(negedge clk); #1;
    chk("t3_end_busy", busy, 0);
    @(negedge clk); #1;
    chk("t3_next_grant", grant, 4'b0001);
    // Test 4: ready_i toggling; only fires advance the burst
    req_valid = 4'b0001;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ready = ready_pat[k][0];
      #1;
      chk($sformatf("t4_busy%0d", k), busy, k < 7);
      if (k < 7) chk($sformatf("t4_rdy%0d", k), req_ready, ready_pat[k]);
    end
    ready = 1;
    // Test 5: asynchronous reset mid-burst
    req_valid = 4'b0010;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_mid_busy", busy, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_valid", valid, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_data", data, 0);
    chk("t5_rst_gid", gid, 0);
    @(negedge clk);
    req_valid = 4'b1111;
    rst_n = 1;
    #1;
    chk("t5_rel_busy", busy, 0);
    @(negedge clk); #1;
    chk("t5_rel_grant", grant, 4'b0001);
    // Test 6: two requesters, 8-pixel bursts alternate 0,1,0,1
    req_valid = '0;
    r2_valid = 2'b11;
    r2_ready = 1;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk); #1;
        chk($sformatf("t6_b%0d_grant", b), grant2, 1 << (b % 2));
        chk($sformatf("t6_b%0d_fire", b), int'(valid2 & r2_ready), 1);
      end
      @(negedge clk); #1;
      chk($sformatf("t6_b%0d_bubble", b), busy2, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/packer_arbiter.md
Name: packer_arbiter

Overview:
Round-robin arbiter that shares one 2-bit pixel packer input among several pixel sources (e.g. camera threshold channels).
Grants one requester for a whole burst of beats_p pixels, so every packed byte holds pixels from a single source.
Sits directly upstream of the packer's unpacked/valid/ready input.
Exports the current grant id so downstream framing logic can tag each byte.

Parameters:
num_req_p, 4, number of requesters; must be at least 2.
width_p, 2, pixel width in bits; must match the packer input width.
beats_p, 4, pixels per grant; must be a nonzero multiple of 4 (whole packer bytes).

Ports:
clk_i  in  1  clock
reset_ni  in  1  reset; one clock; asynchronous, active-low.
req_data_i  in  num_req_p*width_p  pixel of requester k at bits [k*width_p +: width_p]
req_valid_i  in  num_req_p  per-requester valid
req_ready_o  out  num_req_p  per-requester ready
data_o  out  width_p  pixel to the packer
valid_o  out  1  valid to the packer
ready_i  in  1  ready from the packer
grant_o  out  num_req_p  one-hot current grant; all zeros when idle
grant_id_o  out  $clog2(num_req_p)  encoded grant; holds the last grant when idle
busy_o  out  1  high while a burst is in progress

Behaviour:
- Reset (reset_ni low, takes effect immediately, asynchronously):
  - state=IDLE, grant_o=0, grant_id_o=0, busy_o=0, valid_o=0, req_ready_o=0, data_o=0.
  - beat counter=0; priority pointer=num_req_p-1, so requester 0 wins first.
- States: IDLE, BURST.
- IDLE:
  - valid_o=0 and all req_ready_o=0.
  - If any req_valid_i bit is set, choose the first set bit scanning upward from pointer+1 mod num_req_p.
  - Register that requester as the grant, go to BURST, clear the beat counter.
  - Arbitration latency is 1 cycle: the earliest first beat is the cycle after the request is seen.
- BURST, granted requester g:
  - Combinational pass-through: data_o=req_data_i[g], valid_o=req_valid_i[g], req_ready_o[g]=ready_i. All other req_ready_o bits are 0.
  - A fire is valid_o && ready_i. Each fire increments the beat counter.
  - On the fire with counter==beats_p-1: return to IDLE, set pointer=g, clear busy_o/grant_o.
  - The grant is atomic. If g deasserts valid mid-burst, the grant is held indefinitely (no timeout). Other requesters never pre-empt.
- Back-to-back bursts always have exactly one IDLE bubble cycle between the last fire and the next grant.
- Fairness:
  - With all requesters continuously valid, grants cycle 0,1,2,...,num_req_p-1,0.
  - The maximum wait for a continuously valid requester is (num_req_p-1) bursts plus their bubbles.
- The ready_i-to-req_ready_o path and the req_valid_i-to-valid_o path are combinational. There is no data register, so a beat adds zero latency.
- Reset mid-burst:
  - The partial burst is discarded and no further beats are passed.
  - The integrator must reset the packer on the same reset so its partial byte is flushed.
- Requests changing while in BURST have no effect until IDLE.
- Requesters not granted must see req_ready_o=0 in every cycle.

Decomposition:
- Shared package packer_pkg: pixel width constant, default num_req_p, and the state enum (IDLE, BURST).
- One natural sub-module, rr_pick: combinational round-robin selector.
  - Inputs: request vector and pointer. Outputs: one-hot pick and encoded id.
  - Implemented by doubling the request vector and masking below pointer+1.
- The beat counter reuses the team's existing counter_roll with max_val_p=beats_p-1.

Test Plan:
1. Reset release with only req 1 valid, ready_i=1, data stream 1,2,3,0 -> grant_o=0010 one cycle after release, exactly 4 fires, packer byte 8'h39, then 1 idle cycle.
2. All 4 requesters valid continuously, ready_i=1, 12 bursts -> grant_id_o sequence 0,1,2,3,0,1,2,3,0,1,2,3, each burst 4 fires, one bubble between bursts.
3. Req 2 granted, drops valid after 2 beats for 5 cycles while req 0 is valid -> grant stays 2, req_ready_o[0]=0 throughout, burst completes after req 2 resumes.
4. ready_i toggling 1,0,1,0 during a burst -> beats advance only on fires, req_ready_o[g] mirrors ready_i, burst ends after exactly beats_p fires.
5. reset_ni asserted mid-burst (after 2 beats) -> all outputs zero in the same cycle; after release, arbitration restarts with requester 0 at highest priority.
6. beats_p=8, num_req_p=2, both valid -> each grant spans 8 fires (2 packer bytes), alternating 0,1,0,1.
